// File: rtl/sarray_pkg.sv
// Shared definitions for the systolic-array TMMA load controller:
// row stride between consecutive tile rows, controller FSM states and
// the A/B stream tag carried through the outstanding-request FIFO.
package sarray_pkg;

    // Byte distance between consecutive rows of an operand tile.
    localparam int ROW_STRIDE = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Which operand stream a read request (and hence its response) belongs to.
    typedef enum logic {
        TAG_A = 1'b0,
        TAG_B = 1'b1
    } tag_t;

endpackage

// File: rtl/sarray_tag_fifo.sv
// Small synchronous FIFO remembering the stream tag of every outstanding
// read request. Responses come back in order, so the head entry always
// names the stream of the response currently on the bus.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module sarray_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Overflowing pushes and underflowing pops are dropped.
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !clr) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; a push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sarray_tmma_ctrl.sv
// TMMA tile load controller. Accepts one tile instruction, fetches the A
// and B operand rows interleaved (A0, B0, A1, B1, ...), steers each
// in-order response into the left (A) or top (B) edge of the systolic
// array, waits DRAIN_CYC cycles for the array to flush and then pulses
// done_o for one cycle.
//
// Handshake rule on every channel (tinst, ar, r): a transfer happens in
// the cycle where valid and ready are both 1 at the rising clock edge.
// A source holding valid=1 keeps its payload stable until the transfer;
// ready never depends combinationally on valid of the same channel.
module sarray_tmma_ctrl
    import sarray_pkg::*;
#(
    parameter int ROWS      = 16,
    parameter int ADDR_W    = 64,
    parameter int LOAD_W    = 512,
    parameter int MAX_OUT   = 4,
    parameter int DRAIN_CYC = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     tinst_valid_i,
    output logic                     tinst_ready_o,
    input  logic [ADDR_W-1:0]        tinst_addr0_i,
    input  logic [ADDR_W-1:0]        tinst_addr1_i,
    input  logic [1:0]               tinst_precision_i,
    input  logic                     tinst_acc_i,

    output logic                     ar_valid_o,
    input  logic                     ar_ready_i,
    output logic [ADDR_W-1:0]        ar_addr_o,

    input  logic                     r_valid_i,
    output logic                     r_ready_o,
    input  logic [LOAD_W-1:0]        r_data_i,

    output logic                     left_in_valid_o,
    output logic [$clog2(ROWS)-1:0]  left_in_cnt_o,
    output logic [LOAD_W-1:0]        left_in_data_o,

    output logic                     top_in_valid_o,
    output logic [$clog2(ROWS)-1:0]  top_in_cnt_o,
    output logic [LOAD_W-1:0]        top_in_data_o,

    output logic                     top_in_acc_o,
    output logic [1:0]               top_in_precision_o,

    output logic                     done_o
);

    localparam int CNT_W = $clog2(ROWS);
    // Request/response counters run 0..2*ROWS: bit 0 is the stream, bits
    // [CNT_W:1] the row, and the top bit marks the terminal count.
    localparam int REQ_W = CNT_W + 2;
    localparam int DRN_W = $clog2(DRAIN_CYC) + 1;

    localparam logic [REQ_W-1:0] REQ_TOTAL = REQ_W'(2 * ROWS);
    localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(ROWS - 1);
    localparam logic [DRN_W-1:0] DRN_LAST  = DRN_W'(DRAIN_CYC - 1);

    state_t              state;
    state_t              state_nxt;

    logic [ADDR_W-1:0]   addr0_q;
    logic [ADDR_W-1:0]   addr1_q;
    logic [1:0]          prec_q;
    logic                acc_q;

    logic [REQ_W-1:0]    req_cnt;
    logic [REQ_W-1:0]    resp_cnt;
    logic [CNT_W-1:0]    a_rx_cnt;
    logic [CNT_W-1:0]    b_rx_cnt;
    logic [DRN_W-1:0]    drain_cnt;

    logic                tinst_hs;
    logic                ar_hs;
    logic                r_hs;
    logic                last_resp;
    logic                drain_last;

    logic [CNT_W-1:0]    req_row;
    tag_t                req_tag;
    logic [ADDR_W-1:0]   row_off;

    logic                fifo_full;
    logic                fifo_empty;
    logic [0:0]          fifo_head;
    tag_t                resp_tag;

    assign tinst_hs   = tinst_valid_i & tinst_ready_o;
    assign ar_hs      = ar_valid_o & ar_ready_i;
    assign r_hs       = r_valid_i & r_ready_o;
    assign last_resp  = r_hs & (resp_cnt == REQ_TOTAL - 1'b1);
    assign drain_last = (drain_cnt == DRN_LAST);

    // Current request address, a function of registered state only so it
    // stays put while the read channel is back-pressured.
    assign req_row   = req_cnt[CNT_W:1];
    assign req_tag   = req_cnt[0] ? TAG_B : TAG_A;
    assign row_off   = ADDR_W'(req_row) * ADDR_W'(ROW_STRIDE);
    assign ar_addr_o = (req_tag == TAG_B ? addr1_q : addr0_q) + row_off;

    // Responses are only accepted while a request is in flight; anything
    // arriving with an empty tag FIFO (e.g. after a reset) is ignored.
    assign r_ready_o = ~fifo_empty;
    assign resp_tag  = tag_t'(fifo_head);

    assign left_in_valid_o = r_hs & (resp_tag == TAG_A);
    assign top_in_valid_o  = r_hs & (resp_tag == TAG_B);
    assign left_in_cnt_o   = a_rx_cnt;
    assign top_in_cnt_o    = b_rx_cnt;
    assign left_in_data_o  = left_in_valid_o ? r_data_i : '0;
    assign top_in_data_o   = top_in_valid_o  ? r_data_i : '0;

    assign top_in_acc_o       = acc_q;
    assign top_in_precision_o = prec_q;

    sarray_tag_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (1)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (tinst_hs),
        .push      (ar_hs),
        .push_data (req_tag),
        .pop       (r_hs),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and control outputs. The full flag is the occupancy
    // before this cycle's pop, so a same-cycle response never frees a slot.
    always_comb begin
        state_nxt     = state;
        tinst_ready_o = 1'b0;
        ar_valid_o    = 1'b0;
        done_o        = 1'b0;
        case (state)
            ST_IDLE: begin
                tinst_ready_o = 1'b1;
                if (tinst_valid_i) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ar_valid_o = (req_cnt != REQ_TOTAL) & ~fifo_full;
                if (last_resp) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Instruction fields, captured only on an accepted instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr0_q <= '0;
            addr1_q <= '0;
            prec_q  <= '0;
            acc_q   <= 1'b0;
        end else if (tinst_hs) begin
            addr0_q <= tinst_addr0_i;
            addr1_q <= tinst_addr1_i;
            prec_q  <= tinst_precision_i;
            acc_q   <= tinst_acc_i;
        end
    end

    // Request and response progress counters, saturating at terminal counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt  <= '0;
            resp_cnt <= '0;
            a_rx_cnt <= '0;
            b_rx_cnt <= '0;
        end else if (tinst_hs) begin
            req_cnt  <= '0;
            resp_cnt <= '0;
            a_rx_cnt <= '0;
            b_rx_cnt <= '0;
        end else begin
            if (ar_hs && req_cnt != REQ_TOTAL) begin
                req_cnt <= req_cnt + 1'b1;
            end
            if (r_hs) begin
                if (resp_cnt != REQ_TOTAL) begin
                    resp_cnt <= resp_cnt + 1'b1;
                end
                if (resp_tag == TAG_A && a_rx_cnt != ROW_LAST) begin
                    a_rx_cnt <= a_rx_cnt + 1'b1;
                end
                if (resp_tag == TAG_B && b_rx_cnt != ROW_LAST) begin
                    b_rx_cnt <= b_rx_cnt + 1'b1;
                end
            end
        end
    end

    // Array flush timer, running only while in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if (state == ST_DRAIN && !drain_last) begin
            drain_cnt <= drain_cnt + 1'b1;
        end else begin
            drain_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_sarray_tmma_ctrl.sv
// Directed bench for sarray_tmma_ctrl with ROWS=4: a table of tile
// scenarios with hand-computed request addresses, plus hand-written
// reset sequences.
module tb_sarray_tmma_ctrl;

    localparam int ROWS      = 4;
    localparam int ADDR_W    = 64;
    localparam int LOAD_W    = 32;
    localparam int MAX_OUT   = 4;
    localparam int DRAIN_CYC = 32;
    localparam int NREQ      = 2 * ROWS;
    localparam int NVEC      = 5;

    logic              clk;
    logic              rst_n;
    logic              tinst_valid_i;
    logic              tinst_ready_o;
    logic [ADDR_W-1:0] tinst_addr0_i;
    logic [ADDR_W-1:0] tinst_addr1_i;
    logic [1:0]        tinst_precision_i;
    logic              tinst_acc_i;
    logic              ar_valid_o;
    logic              ar_ready_i;
    logic [ADDR_W-1:0] ar_addr_o;
    logic              r_valid_i;
    logic              r_ready_o;
    logic [LOAD_W-1:0] r_data_i;
    logic              left_in_valid_o;
    logic [1:0]        left_in_cnt_o;
    logic [LOAD_W-1:0] left_in_data_o;
    logic              top_in_valid_o;
    logic [1:0]        top_in_cnt_o;
    logic [LOAD_W-1:0] top_in_data_o;
    logic              top_in_acc_o;
    logic [1:0]        top_in_precision_o;
    logic              done_o;

    sarray_tmma_ctrl #(
        .ROWS      (ROWS),
        .ADDR_W    (ADDR_W),
        .LOAD_W    (LOAD_W),
        .MAX_OUT   (MAX_OUT),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .tinst_valid_i      (tinst_valid_i),
        .tinst_ready_o      (tinst_ready_o),
        .tinst_addr0_i      (tinst_addr0_i),
        .tinst_addr1_i      (tinst_addr1_i),
        .tinst_precision_i  (tinst_precision_i),
        .tinst_acc_i        (tinst_acc_i),
        .ar_valid_o         (ar_valid_o),
        .ar_ready_i         (ar_ready_i),
        .ar_addr_o          (ar_addr_o),
        .r_valid_i          (r_valid_i),
        .r_ready_o          (r_ready_o),
        .r_data_i           (r_data_i),
        .left_in_valid_o    (left_in_valid_o),
        .left_in_cnt_o      (left_in_cnt_o),
        .left_in_data_o     (left_in_data_o),
        .top_in_valid_o     (top_in_valid_o),
        .top_in_cnt_o       (top_in_cnt_o),
        .top_in_data_o      (top_in_data_o),
        .top_in_acc_o       (top_in_acc_o),
        .top_in_precision_o (top_in_precision_o),
        .done_o             (done_o)
    );

    // Clock and cycle bookkeeping.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr0;
        logic [63:0] addr1;
        logic [1:0]  prec;
        logic        acc;
        int          delay;
        bit          rand_ready;
        bit          hold;
        int          exp_burst;
        logic [63:0] exp_addr [NREQ];
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } resp_t;

    vec_t        vecs [NVEC];
    resp_t       rq [$];
    logic [31:0] exp_q [$];
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          last_done_cyc;

    function automatic logic [31:0] rdata(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present the instruction, then run the tile to done_o acting as the
    // memory model: requests are answered in order after v.delay cycles.
    task automatic run_tile(input int idx);
        vec_t        v;
        resp_t       e;
        int          req_idx, resp_idx, burst, last_resp_cyc, acc_cyc, start;
        int          bad_ready, bad_inj, bad_out;
        bit          accepted, got_done, prev_stall, r_hs;
        logic [63:0] prev_addr;
        logic [31:0] exp_d;
        v = vecs[idx];
        req_idx = 0; resp_idx = 0; burst = 0; last_resp_cyc = 0; acc_cyc = 0;
        bad_ready = 0; bad_inj = 0; bad_out = 0;
        accepted = 0; got_done = 0; prev_stall = 0; prev_addr = '0;
        rq.delete();
        exp_q.delete();

        for (int t = 0; t < 10 && !accepted; t++) begin
            @(negedge clk); cyc++;
            tinst_valid_i = 1'b1;
            tinst_addr0_i = v.addr0;
            tinst_addr1_i = v.addr1;
            tinst_precision_i = v.prec;
            tinst_acc_i = v.acc;
            ar_ready_i = 1'b1;
            r_valid_i = 1'b0;
            #1;
            if (tinst_ready_o) begin
                accepted = 1;
                acc_cyc = cyc;
            end
        end
        check("accept", 64'(accepted), 64'd1);
        if (idx > 0 && vecs[idx-1].hold) begin
            check("busy_accept_cycle", 64'(acc_cyc), 64'(last_done_cyc + 1));
        end

        start = cyc;
        while (!got_done && (cyc - start) < 400) begin
            @(negedge clk); cyc++;
            tinst_valid_i = v.hold;
            tinst_addr0_i = ~v.addr0;
            tinst_addr1_i = ~v.addr1;
            tinst_precision_i = ~v.prec;
            tinst_acc_i = ~v.acc;
            ar_ready_i = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                r_valid_i = 1'b1;
                r_data_i = rq[0].data;
            end else begin
                r_valid_i = 1'b0;
                r_data_i = $urandom;
            end
            #1;
            if (prev_stall) begin
                check("stall_valid", 64'(ar_valid_o), 64'd1);
                check("stall_addr", ar_addr_o, prev_addr);
            end
            if (r_valid_i) check("r_ready", 64'(r_ready_o), 64'd1);
            if (tinst_ready_o) bad_ready++;
            r_hs = r_valid_i && r_ready_o;
            if (ar_valid_o && ar_ready_i) begin
                check("req_in_range", 64'(req_idx < NREQ), 64'd1);
                if (req_idx < NREQ) begin
                    check($sformatf("ar_addr[%0d]", req_idx), ar_addr_o, v.exp_addr[req_idx]);
                    exp_q.push_back(rdata(v.exp_addr[req_idx]));
                end
                if (req_idx - resp_idx >= MAX_OUT) bad_out++;
                if (resp_idx == 0 && !r_hs) burst++;
                e.data = rdata(ar_addr_o);
                e.due = cyc + v.delay;
                rq.push_back(e);
                req_idx++;
            end
            if (r_hs) begin
                void'(rq.pop_front());
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
                if (resp_idx % 2 == 0) begin
                    check("left_valid", 64'(left_in_valid_o), 64'd1);
                    check("left_other", 64'(top_in_valid_o), 64'd0);
                    check("left_cnt", 64'(left_in_cnt_o), 64'(resp_idx / 2));
                    check("left_data", 64'(left_in_data_o), 64'(exp_d));
                end else begin
                    check("top_valid", 64'(top_in_valid_o), 64'd1);
                    check("top_other", 64'(left_in_valid_o), 64'd0);
                    check("top_cnt", 64'(top_in_cnt_o), 64'(resp_idx / 2));
                    check("top_data", 64'(top_in_data_o), 64'(exp_d));
                end
                check("precision", 64'(top_in_precision_o), 64'(v.prec));
                check("acc", 64'(top_in_acc_o), 64'(v.acc));
                resp_idx++;
                last_resp_cyc = cyc;
            end else if (left_in_valid_o || top_in_valid_o) begin
                bad_inj++;
            end
            prev_stall = ar_valid_o && !ar_ready_i;
            prev_addr = ar_addr_o;
            if (done_o) begin
                got_done = 1;
                last_done_cyc = cyc;
                if (v.hold && idx + 1 < NVEC) begin
                    tinst_addr0_i = vecs[idx+1].addr0;
                    tinst_addr1_i = vecs[idx+1].addr1;
                    tinst_precision_i = vecs[idx+1].prec;
                    tinst_acc_i = vecs[idx+1].acc;
                end
            end
        end
        check("done_seen", 64'(got_done), 64'd1);
        if (got_done) check("done_cycle", 64'(cyc), 64'(last_resp_cyc + 1 + DRAIN_CYC));
        check("req_total", 64'(req_idx), 64'(NREQ));
        check("resp_total", 64'(resp_idx), 64'(NREQ));
        check("busy_ready_cycles", 64'(bad_ready), 64'd0);
        check("spurious_inject", 64'(bad_inj), 64'd0);
        check("outstanding_over", 64'(bad_out), 64'd0);
        if (v.exp_burst >= 0) check("burst_before_resp", 64'(burst), 64'(v.exp_burst));
        if (!v.hold) begin
            @(negedge clk); cyc++;
            tinst_valid_i = 1'b0;
            r_valid_i = 1'b0;
            #1;
            check("idle_ready", 64'(tinst_ready_o), 64'd1);
            check("done_single", 64'(done_o), 64'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tinst_ready"}, 64'(tinst_ready_o), 64'd1);
        check({tag, "_ar_valid"}, 64'(ar_valid_o), 64'd0);
        check({tag, "_r_ready"}, 64'(r_ready_o), 64'd0);
        check({tag, "_done"}, 64'(done_o), 64'd0);
        check({tag, "_inj_valid"}, 64'({left_in_valid_o, top_in_valid_o}), 64'd0);
        check({tag, "_ar_addr"}, ar_addr_o, 64'd0);
        check({tag, "_cnts"}, 64'({left_in_cnt_o, top_in_cnt_o}), 64'd0);
        check({tag, "_data"}, 64'({left_in_data_o, top_in_data_o}), 64'd0);
    endtask

    initial begin
        int n_acc;
        bit acc_ok;
        cyc = 0; n_checks = 0; n_fail = 0; last_done_cyc = 0;

        // Scenario table: basic, outstanding limit, backpressure,
        // wrapping B base with busy hold, and the instruction queued behind it.
        vecs[0].addr0 = 64'h1000; vecs[0].addr1 = 64'h8000;
        vecs[0].prec = 2'b01; vecs[0].acc = 1'b0; vecs[0].delay = 1;
        vecs[0].rand_ready = 0; vecs[0].hold = 0; vecs[0].exp_burst = 1;
        vecs[0].exp_addr = '{64'h1000, 64'h8000, 64'h1100, 64'h8100,
                             64'h1200, 64'h8200, 64'h1300, 64'h8300};

        vecs[1].addr0 = 64'h0000_0002_0000_0040; vecs[1].addr1 = 64'h3_0000;
        vecs[1].prec = 2'b10; vecs[1].acc = 1'b1; vecs[1].delay = 20;
        vecs[1].rand_ready = 0; vecs[1].hold = 0; vecs[1].exp_burst = 4;
        vecs[1].exp_addr = '{64'h2_0000_0040, 64'h3_0000, 64'h2_0000_0140, 64'h3_0100,
                             64'h2_0000_0240, 64'h3_0200, 64'h2_0000_0340, 64'h3_0300};

        vecs[2].addr0 = 64'hABC0; vecs[2].addr1 = 64'h7F00;
        vecs[2].prec = 2'b11; vecs[2].acc = 1'b0; vecs[2].delay = 3;
        vecs[2].rand_ready = 1; vecs[2].hold = 0; vecs[2].exp_burst = -1;
        vecs[2].exp_addr = '{64'hABC0, 64'h7F00, 64'hACC0, 64'h8000,
                             64'hADC0, 64'h8100, 64'hAEC0, 64'h8200};

        vecs[3].addr0 = 64'h0; vecs[3].addr1 = 64'hFFFF_FFFF_FFFF_FF00;
        vecs[3].prec = 2'b00; vecs[3].acc = 1'b1; vecs[3].delay = 2;
        vecs[3].rand_ready = 0; vecs[3].hold = 1; vecs[3].exp_burst = -1;
        vecs[3].exp_addr = '{64'h0, 64'hFFFF_FFFF_FFFF_FF00, 64'h100, 64'h0,
                             64'h200, 64'h100, 64'h300, 64'h200};

        vecs[4].addr0 = 64'hFFFF_FFFF_FFFF_FE00; vecs[4].addr1 = 64'h4000;
        vecs[4].prec = 2'b10; vecs[4].acc = 1'b0; vecs[4].delay = 1;
        vecs[4].rand_ready = 0; vecs[4].hold = 0; vecs[4].exp_burst = 1;
        vecs[4].exp_addr = '{64'hFFFF_FFFF_FFFF_FE00, 64'h4000, 64'hFFFF_FFFF_FFFF_FF00, 64'h4100,
                             64'h0, 64'h4200, 64'h100, 64'h4300};

        // Power-on reset.
        rst_n = 1'b0;
        tinst_valid_i = 1'b0; tinst_addr0_i = '0; tinst_addr1_i = '0;
        tinst_precision_i = '0; tinst_acc_i = 1'b0;
        ar_ready_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk); cyc++;
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_tile(i);
        end

        // Mid-tile reset after three accepted requests.
        acc_ok = 0;
        for (int t = 0; t < 10 && !acc_ok; t++) begin
            @(negedge clk); cyc++;
            tinst_valid_i = 1'b1;
            tinst_addr0_i = vecs[0].addr0; tinst_addr1_i = vecs[0].addr1;
            tinst_precision_i = vecs[0].prec; tinst_acc_i = vecs[0].acc;
            ar_ready_i = 1'b1; r_valid_i = 1'b0;
            #1;
            acc_ok = tinst_ready_o;
        end
        check("mid_accept", 64'(acc_ok), 64'd1);
        n_acc = 0;
        for (int t = 0; t < 20 && n_acc < 3; t++) begin
            @(negedge clk); cyc++;
            tinst_valid_i = 1'b0;
            #1;
            if (ar_valid_o && ar_ready_i) n_acc++;
        end
        check("mid_three_reqs", 64'(n_acc), 64'd3);
        @(negedge clk); cyc++;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk); cyc++;
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk); cyc++;
            r_valid_i = 1'b1;
            r_data_i = 32'hDEAD_0000 + 32'(t);
            #1;
            check("stale_r_ready", 64'(r_ready_o), 64'd0);
            check("stale_inject", 64'({left_in_valid_o, top_in_valid_o}), 64'd0);
            check("stale_idle_ready", 64'(tinst_ready_o), 64'd1);
        end
        r_valid_i = 1'b0;

        // Recovery: a full tile after the abandoned one.
        run_tile(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sarray_tmma_ctrl.md
SARRAY_TMMA_CTRL -- requirements
Module: sarray_tmma_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ROWS, 16, rows per operand tile (power of two).
- ADDR_W, 64, address width.
- LOAD_W, 512, read-data and row width.
- MAX_OUT, 4, maximum outstanding read requests (power of two).
- DRAIN_CYC, 32, array flush cycles after the last row is injected.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- tinst_valid_i / tinst_ready_o, in / out, 1 / 1, TMMA instruction handshake.
- tinst_addr0_i / tinst_addr1_i, in, ADDR_W, A and B tile base addresses.
- tinst_precision_i, in, 2, precision code.
- tinst_acc_i, in, 1, accumulate flag.
- ar_valid_o / ar_ready_i / ar_addr_o, out / in / out, 1 / 1 / ADDR_W, read-request channel.
- r_valid_i / r_ready_o / r_data_i, in / out / in, 1 / 1 / LOAD_W, in-order read-response channel.
- left_in_valid_o / left_in_cnt_o / left_in_data_o, out, 1 / log2(ROWS) / LOAD_W, A-row injection.
- top_in_valid_o / top_in_cnt_o / top_in_data_o, out, 1 / log2(ROWS) / LOAD_W, B-row injection.
- top_in_acc_o / top_in_precision_o, out, 1 / 2, latched instruction fields.
- done_o, out, 1, single-cycle tile-complete pulse.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, DRAIN and DONE; tinst_ready_o SHALL be 1 only in IDLE.
REQ-004 On a tinst handshake, the FSM SHALL latch addr0, addr1, precision and acc, clear all counters, and enter LOAD in the next cycle.
REQ-005 In LOAD, requests SHALL be issued in the order A0, B0, A1, B1, ... A(ROWS-1), B(ROWS-1).
- A row k address = addr0 + k*256.
- B row k address = addr1 + k*256.
- Address arithmetic SHALL be modulo 2^ADDR_W.
REQ-006 ar_valid_o SHALL be 1 in LOAD while fewer than 2*ROWS requests have been issued and outstanding < MAX_OUT.
- A response popped in the same cycle SHALL NOT free a slot for that cycle.
- ar_addr_o SHALL be held stable while ar_valid_o=1 and ar_ready_i=0.
REQ-007 Each accepted request SHALL push its type (A/B) into a tag FIFO of depth MAX_OUT.
- Each response handshake SHALL pop the tag FIFO.
- A simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-008 r_ready_o SHALL equal (outstanding != 0); r_valid_i with no outstanding request SHALL be ignored.
REQ-009 Injection SHALL be combinational in the response cycle.
- left_in_valid_o = handshake & tag==A; top_in_valid_o = handshake & tag==B.
- Data SHALL pass through from r_data_i.
- The cnt outputs SHALL equal the per-stream received-row count (0..ROWS-1).
REQ-010 The FSM SHALL enter DRAIN in the cycle after the 2*ROWS-th response, stay there for exactly DRAIN_CYC cycles, then enter DONE for one cycle.
- done_o=1 only in DONE.
- The FSM SHALL return to IDLE after DONE.
- Net result: done_o rises at last-response cycle + 1 + DRAIN_CYC.
REQ-011 A tinst_valid_i outside IDLE SHALL NOT be accepted, and SHALL NOT disturb the latched fields.
REQ-012 Row counters SHALL wrap-free saturate at their terminal counts; no request SHALL be issued after B(ROWS-1).

Reset
REQ-013 On reset, the FSM SHALL enter IDLE and all counters and the tag FIFO SHALL clear.
- Output reset values: tinst_ready_o=1; all valids, r_ready_o and done_o = 0; addr, cnt and data outputs = 0.
REQ-014 Reset mid-tile SHALL abandon the tile; responses arriving after reset SHALL be ignored by REQ-008.

Structure
REQ-015 The shared package sarray_pkg SHALL hold the ROW_STRIDE=256 constant, the FSM state enum, and the A/B tag enum.
REQ-016 The tag FIFO SHALL be the sub-module sarray_tag_fifo (parameters DEPTH and WIDTH=1, outputs full/empty).

Verification
REQ-017 Basic tile: ROWS=4, addr0=0x1000, addr1=0x8000, ready always 1, 1-cycle response.
- ar_addr sequence SHALL be 0x1000, 0x8000, 0x1100, 0x8100, ... 0x8300.
- 4 left and 4 top pulses with cnt 0..3.
- done_o at last response + 33.
REQ-018 Outstanding limit: responses delayed 20 cycles -> exactly MAX_OUT=4 requests accepted before the first response.
REQ-019 Backpressure: ar_ready_i toggled randomly -> ar_addr_o stable while stalled; no request lost or duplicated.
REQ-020 Busy instruction: tinst_valid_i held high throughout -> second instruction accepted only in the cycle after done_o.
REQ-021 Wrap: addr1=0xFFFF_FFFF_FFFF_FF00 -> B row 1 address = 0x0.
REQ-022 Mid-tile reset: assert rst_n=0 after 3 requests -> IDLE, tinst_ready_o=1, stale response ignored (no injection pulse).
